// File: rtl/spi_master_ctrl.sv
// Single-byte SPI master: turns a req/ready handshake into a 10-period
// command+data+trailer frame on ssel/sclk/mosi and captures miso LSB first.
module spi_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       ssel,
    output logic       mosi,
    input  logic       miso
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, XFER, HOLD, DONE} state_t;

    state_t     state, state_n;
    logic [DW-1:0] div, div_n;
    logic [3:0] fcnt, fcnt_n;
    logic [7:0] txsr, txsr_n;
    logic [7:0] shadow, shadow_n;
    logic [7:0] rdata_n;
    logic       wr_q, wr_q_n;
    logic       ready_n, done_n, sclk_n, ssel_n, mosi_n;
    logic       wrap;

    assign wrap = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            div    <= '0;
            fcnt   <= '0;
            txsr   <= '0;
            shadow <= '0;
            wr_q   <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b0;
            rdata  <= '0;
            sclk   <= 1'b0;
            ssel   <= 1'b1;
            mosi   <= 1'b0;
        end else begin
            state  <= state_n;
            div    <= div_n;
            fcnt   <= fcnt_n;
            txsr   <= txsr_n;
            shadow <= shadow_n;
            wr_q   <= wr_q_n;
            ready  <= ready_n;
            done   <= done_n;
            rdata  <= rdata_n;
            sclk   <= sclk_n;
            ssel   <= ssel_n;
            mosi   <= mosi_n;
        end
    end

    always_comb begin
        state_n  = state;
        div_n    = div;
        fcnt_n   = fcnt;
        txsr_n   = txsr;
        shadow_n = shadow;
        wr_q_n   = wr_q;
        ready_n  = ready;
        done_n   = 1'b0;
        rdata_n  = rdata;
        sclk_n   = sclk;
        ssel_n   = ssel;
        mosi_n   = mosi;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (req) begin
                    state_n = XFER;
                    ready_n = 1'b0;
                    wr_q_n  = wr;
                    txsr_n  = wdata;
                    div_n   = '0;
                    fcnt_n  = '0;
                    ssel_n  = 1'b0;
                    sclk_n  = 1'b0;
                    mosi_n  = wr;
                end
            end
            XFER: begin
                if (wrap) begin
                    div_n  = '0;
                    sclk_n = ~sclk;
                    // sclk high -> this toggle is a falling edge; fcnt counts completed periods
                    if (sclk) begin
                        fcnt_n = fcnt + 4'd1;
                        if (!wr_q && fcnt >= 4'd1 && fcnt <= 4'd8)
                            shadow_n = {miso, shadow[7:1]};
                        if (wr_q && fcnt <= 4'd7) begin
                            mosi_n = txsr[7];
                            txsr_n = {txsr[6:0], 1'b0};
                        end else begin
                            mosi_n = 1'b0;
                        end
                        if (fcnt == 4'd9)
                            state_n = HOLD;
                    end
                end else begin
                    div_n = div + DW'(1);
                end
            end
            HOLD: begin
                if (wrap) begin
                    div_n   = '0;
                    state_n = DONE;
                    ssel_n  = 1'b1;
                    done_n  = 1'b1;
                    if (!wr_q)
                        rdata_n = shadow;
                end else begin
                    div_n = div + DW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a frame-timing model compared every cycle for a
// CLK_DIV=4 and a CLK_DIV=2 instance, plus directed literal checks.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, req4, wr4, miso4, rdy4, dn4, sc4, ss4, mo4;
    logic [7:0] wd4, rd4;
    logic       rst2, req2, wr2, miso2, rdy2, dn2, sc2, ss2, mo2;
    logic [7:0] wd2, rd2;

    spi_master_ctrl #(.CLK_DIV(4)) u4 (
        .clk(clk), .rst(rst4), .req(req4), .wr(wr4), .wdata(wd4),
        .ready(rdy4), .done(dn4), .rdata(rd4),
        .sclk(sc4), .ssel(ss4), .mosi(mo4), .miso(miso4));

    spi_master_ctrl #(.CLK_DIV(2)) u2 (
        .clk(clk), .rst(rst2), .req(req2), .wr(wr2), .wdata(wd2),
        .ready(rdy2), .done(dn2), .rdata(rd2),
        .sclk(sc2), .ssel(ss2), .mosi(mo2), .miso(miso2));

    // Model: n = cycles since the accepting edge; frame shape follows from n alone.
    typedef struct packed {
        bit         busy;
        int         n;
        bit         wr;
        logic [7:0] wd;
        logic [7:0] rd;
        int         acc;
    } mdl_t;

    int   total = 0, bad = 0, cyc = 0;
    bit   chk_on = 0;
    mdl_t m4 = '0, m2 = '0;
    logic [7:0] mb4 = 8'h00, mb2 = 8'h00;
    logic q4[$];
    logic psc4 = 1'b0;
    int   dcnt4 = 0, lat4 = 0, dcnt2 = 0, lat2 = 0;

    function automatic mdl_t step(mdl_t m, logic r, logic q, logic w, logic [7:0] d,
                                  logic [7:0] mb, int D, int c);
        mdl_t o = m;
        if (r) begin
            o.busy = 0; o.n = 0; o.rd = 8'h00;
        end else if (!m.busy) begin
            if (q) begin o.busy = 1; o.n = 0; o.wr = w; o.wd = d; o.acc = c; end
        end else begin
            o.n = m.n + 1;
            if (o.n == 21*D && !m.wr) o.rd = mb;
            if (o.n == 21*D + 1) o.busy = 0;
        end
        return o;
    endfunction

    function automatic logic mis(mdl_t m, logic [7:0] mb, int D);
        int p;
        if (!m.busy || m.wr || m.n >= 20*D) return 1'b0;
        p = m.n / (2*D) + 1;
        if (p >= 2 && p <= 9) return mb[p-2];
        return 1'b0;
    endfunction

    task automatic chk8(string a, string b, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s.%s: got %h want %h (cyc %0d)", a, b, act, exp, cyc);
        end
    endtask

    task automatic chk1(string a, string b, logic act, logic exp);
        chk8(a, b, {7'd0, act}, {7'd0, exp});
    endtask

    task automatic cmp(string nm, mdl_t m, int D, logic rdy, logic dn, logic sc,
                       logic ss, logic mo, logic [7:0] rd);
        logic e_rdy, e_dn, e_sc, e_ss, e_mo;
        int p;
        e_rdy = 1; e_dn = 0; e_sc = 0; e_ss = 1; e_mo = 0;
        if (m.busy) begin
            e_rdy = 0;
            if (m.n < 20*D) begin
                e_ss = 0;
                e_sc = ((m.n / D) % 2) == 1;
                p = m.n / (2*D) + 1;
                if (p == 1) e_mo = m.wr;
                else if (m.wr && p <= 9) e_mo = m.wd[9-p];
            end else if (m.n < 21*D) begin
                e_ss = 0;
            end else begin
                e_dn = 1;
            end
        end
        chk1(nm, "ready", rdy, e_rdy);
        chk1(nm, "done", dn, e_dn);
        chk1(nm, "sclk", sc, e_sc);
        chk1(nm, "ssel", ss, e_ss);
        chk1(nm, "mosi", mo, e_mo);
        chk8(nm, "rdata", rd, m.rd);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        m4 = step(m4, rst4, req4, wr4, wd4, mb4, 4, cyc);
        m2 = step(m2, rst2, req2, wr2, wd2, mb2, 2, cyc);
        #1;
        if (chk_on) begin
            cmp("d4", m4, 4, rdy4, dn4, sc4, ss4, mo4, rd4);
            cmp("d2", m2, 2, rdy2, dn2, sc2, ss2, mo2, rd2);
        end
        miso4 = mis(m4, mb4, 4);
        miso2 = mis(m2, mb2, 2);
        if (sc4 && !psc4) q4.push_back(mo4);
        psc4 = sc4;
        if (dn4) begin dcnt4++; lat4 = cyc - m4.acc; end
        if (dn2) begin dcnt2++; lat2 = cyc - m2.acc; end
    end

    // Called at a negedge; returns one negedge later, after the accepting edge.
    task automatic go(int which, logic w, logic [7:0] d);
        if (which == 4) begin req4 = 1; wr4 = w; wd4 = d; end
        else            begin req2 = 1; wr2 = w; wd2 = d; end
        @(negedge clk);
        req4 = 0; req2 = 0;
    endtask

    task automatic wait_done(int which, int budget);
        int start, k;
        start = (which == 4) ? dcnt4 : dcnt2;
        k = 0;
        while (((which == 4) ? dcnt4 : dcnt2) == start && k < budget) begin
            @(negedge clk); k++;
        end
        if (((which == 4) ? dcnt4 : dcnt2) == start) begin
            total++; bad++;
            $display("FAIL timeout: no done on d%0d within %0d cycles", which, budget);
        end
    endtask

    // Compares 10 rising-edge mosi samples starting at q4[off]; exp[9] is period 1.
    task automatic chkq(string nm, int off, logic [9:0] exp);
        total++;
        if (q4.size() < off + 10) begin
            bad++;
            $display("FAIL %s: only %0d sclk rises, want %0d", nm, q4.size(), off + 10);
        end else begin
            for (int i = 0; i < 10; i++)
                if (q4[off+i] !== exp[9-i]) begin
                    bad++;
                    $display("FAIL %s: period %0d mosi got %b want %b", nm, i+1, q4[off+i], exp[9-i]);
                    break;
                end
        end
    endtask

    initial begin
        int hi, dc;
        rst4 = 1; req4 = 0; wr4 = 0; wd4 = 0; miso4 = 0;
        rst2 = 1; req2 = 0; wr2 = 0; wd2 = 0; miso2 = 0;
        repeat (3) @(negedge clk);
        rst4 = 0; rst2 = 0; chk_on = 1;
        chk1("reset", "ready", rdy4, 1'b1);
        chk1("reset", "done", dn4, 1'b0);
        chk1("reset", "ssel", ss4, 1'b1);
        chk1("reset", "sclk", sc4, 1'b0);
        chk1("reset", "mosi", mo4, 1'b0);
        chk8("reset", "rdata", rd4, 8'h00);

        // write A5
        q4.delete();
        go(4, 1, 8'hA5);
        wait_done(4, 200);
        chk8("wr_a5", "done_lat", lat4[7:0], 8'd84);
        chk8("wr_a5", "rdata", rd4, 8'h00);
        @(negedge clk);
        chk1("wr_a5", "ready_after", rdy4, 1'b1);
        chkq("wr_a5_mosi", 0, 10'b1_10100101_0);

        // read back: slave echoes A5 LSB first
        mb4 = 8'hA5;
        q4.delete();
        go(4, 0, 8'h00);
        wait_done(4, 200);
        chk8("rd_a5", "rdata", rd4, 8'hA5);
        chkq("rd_mosi", 0, 10'b0);

        // busy rejection: req held, wdata changes mid-frame
        q4.delete();
        req4 = 1; wr4 = 1; wd4 = 8'h3C;
        repeat (10) @(negedge clk);
        wd4 = 8'hFF;
        wait_done(4, 200);
        @(negedge clk);
        chk1("busy", "ready_rise", rdy4, 1'b1);
        @(negedge clk);
        chk1("busy", "restart_ssel", ss4, 1'b0);
        req4 = 0;
        wait_done(4, 200);
        chkq("busy_f1", 0, 10'b1_00111100_0);
        chkq("busy_f2", 10, 10'b1_11111111_0);
        @(negedge clk);

        // back-to-back 00 then FF
        q4.delete();
        req4 = 1; wr4 = 1; wd4 = 8'h00;
        @(negedge clk);
        wd4 = 8'hFF;
        wait_done(4, 200);
        hi = 0;
        while (ss4 && hi < 10) begin hi++; @(negedge clk); end
        req4 = 0;
        chk8("b2b", "ssel_high_cycles", hi[7:0], 8'd2);
        wait_done(4, 200);
        chkq("b2b_f1", 0, 10'b1_00000000_0);
        chkq("b2b_f2", 10, 10'b1_11111111_0);
        @(negedge clk);

        // reset mid-frame
        go(4, 1, 8'h5A);
        repeat (29) @(negedge clk);
        rst4 = 1;
        @(negedge clk);
        rst4 = 0;
        chk1("midrst", "ssel", ss4, 1'b1);
        chk1("midrst", "sclk", sc4, 1'b0);
        chk1("midrst", "mosi", mo4, 1'b0);
        chk1("midrst", "ready", rdy4, 1'b1);
        chk8("midrst", "rdata", rd4, 8'h00);
        dc = dcnt4;
        repeat (100) @(negedge clk);
        chk8("midrst", "no_done", dcnt4[7:0], dc[7:0]);
        q4.delete();
        go(4, 1, 8'h81);
        wait_done(4, 200);
        chkq("wr_81", 0, 10'b1_10000001_0);
        chk8("wr_81", "done_lat", lat4[7:0], 8'd84);

        // minimum divider read: miso 0,1,1,1,0,0,0,1 in periods 2..9
        mb2 = 8'h8E;
        go(2, 0, 8'h00);
        wait_done(2, 200);
        chk8("div2", "done_lat", lat2[7:0], 8'd42);
        chk8("div2", "rdata", rd2, 8'h8E);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
